// File: rtl/nco_out_serializer.sv
// Serializes parallel X/Y NCO samples into 2-bit slices (LSB first) behind a
// one-cycle Rdy pulse, with a one-deep pending buffer for mid-frame arrivals.
module nco_out_serializer #(
   parameter int W     = 12,
   parameter int SLICE = 2,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             smp_vld,
   input  logic [W-1:0]     x_in,
   input  logic [W-1:0]     y_in,
   input  logic             is_in,
   output logic             Rdy,
   output logic [SLICE-1:0] Xout,
   output logic [SLICE-1:0] Yout,
   output logic             ISout,
   output logic             busy,
   output logic [7:0]       drop_cnt
);

   localparam int NSLICE = W / SLICE;
   localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int GW     = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);
   localparam logic [GW-1:0] G_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_SHIFT,
      ST_GAP
   } state_t;

   state_t           r_state;
   logic [KW-1:0]    r_k;
   logic [GW-1:0]    r_gap;
   logic [W-1:0]     r_x_sh;
   logic [W-1:0]     r_y_sh;
   logic             r_is_sh;
   logic             r_pend_vld;
   logic [W-1:0]     r_pend_x;
   logic [W-1:0]     r_pend_y;
   logic             r_pend_is;
   logic [7:0]       r_drop;
   logic             r_rdy;
   logic [SLICE-1:0] r_xout;
   logic [SLICE-1:0] r_yout;
   logic             r_isout;

   logic             w_frame_end;
   logic             w_launch_pt;
   logic             w_launch;
   logic [W-1:0]     w_ld_x;
   logic [W-1:0]     w_ld_y;
   logic             w_ld_is;

   // The last cycle of a frame is also a launch point so frames can abut.
   always_comb begin
      w_frame_end = 1'b0;
      if (GAP == 0) begin
         w_frame_end = (r_state == ST_SHIFT) && (r_k == K_LAST);
      end else begin
         w_frame_end = (r_state == ST_GAP) && (r_gap == G_LAST);
      end
   end

   assign w_launch_pt = (r_state == ST_IDLE) || w_frame_end;
   assign w_launch    = w_launch_pt && (r_pend_vld || smp_vld);
   assign w_ld_x      = r_pend_vld ? r_pend_x  : x_in;
   assign w_ld_y      = r_pend_vld ? r_pend_y  : y_in;
   assign w_ld_is     = r_pend_vld ? r_pend_is : is_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_k     <= '0;
         r_gap   <= '0;
         r_x_sh  <= '0;
         r_y_sh  <= '0;
         r_is_sh <= 1'b0;
         r_rdy   <= 1'b0;
         r_xout  <= '0;
         r_yout  <= '0;
         r_isout <= 1'b0;
      end else begin
         r_rdy  <= 1'b0;
         r_xout <= '0;
         r_yout <= '0;
         if (w_launch_pt) begin
            if (w_launch) begin
               r_state <= ST_START;
               r_rdy   <= 1'b1;
               r_x_sh  <= w_ld_x;
               r_y_sh  <= w_ld_y;
               r_is_sh <= w_ld_is;
            end else begin
               r_state <= ST_IDLE;
            end
         end else begin
            case (r_state)
               ST_START: begin
                  r_state <= ST_SHIFT;
                  r_k     <= '0;
                  r_isout <= r_is_sh;
                  r_xout  <= r_x_sh[SLICE-1:0];
                  r_yout  <= r_y_sh[SLICE-1:0];
                  r_x_sh  <= r_x_sh >> SLICE;
                  r_y_sh  <= r_y_sh >> SLICE;
               end
               ST_SHIFT: begin
                  if (r_k == K_LAST) begin
                     r_state <= ST_GAP;
                     r_gap   <= '0;
                  end else begin
                     r_k    <= r_k + 1'b1;
                     r_xout <= r_x_sh[SLICE-1:0];
                     r_yout <= r_y_sh[SLICE-1:0];
                     r_x_sh <= r_x_sh >> SLICE;
                     r_y_sh <= r_y_sh >> SLICE;
                  end
               end
               ST_GAP: begin
                  r_gap <= r_gap + 1'b1;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // A launch point drains pending first; a coincident strobe refills it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend_vld <= 1'b0;
         r_pend_x   <= '0;
         r_pend_y   <= '0;
         r_pend_is  <= 1'b0;
         r_drop     <= '0;
      end else if (w_launch_pt) begin
         if (r_pend_vld) begin
            r_pend_vld <= smp_vld;
            if (smp_vld) begin
               r_pend_x  <= x_in;
               r_pend_y  <= y_in;
               r_pend_is <= is_in;
            end
         end
      end else if (smp_vld) begin
         r_pend_vld <= 1'b1;
         r_pend_x   <= x_in;
         r_pend_y   <= y_in;
         r_pend_is  <= is_in;
         if (r_pend_vld && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
         end
      end
   end

   assign Rdy      = r_rdy;
   assign Xout     = r_xout;
   assign Yout     = r_yout;
   assign ISout    = r_isout;
   assign busy     = (r_state != ST_IDLE);
   assign drop_cnt = r_drop;

endmodule

// File: tb/tb_nco_out_serializer.sv
// Directed bench for nco_out_serializer: one instance with GAP=1, one with GAP=0,
// sharing clock, reset and sample data.
module tb_nco_out_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vld1 = 1'b0;
   logic        vld0 = 1'b0;
   logic [11:0] x_in = '0;
   logic [11:0] y_in = '0;
   logic        is_in = 1'b0;

   logic       rdy1, is1, busy1, rdy0, is0, busy0;
   logic [1:0] xo1, yo1, xo0, yo0;
   logic [7:0] drop1, drop0;

   int checks = 0;
   int errors = 0;

   logic        sv  [0:63];
   logic [11:0] sx  [0:63];
   logic [11:0] sy  [0:63];
   logic        sis [0:63];

   logic       c_rdy  [0:63];
   logic [1:0] c_x    [0:63];
   logic [1:0] c_y    [0:63];
   logic       c_is   [0:63];
   logic       c_busy [0:63];
   logic [7:0] c_drop [0:63];

   nco_out_serializer #(.W(12), .SLICE(2), .GAP(1)) u_dut1 (
      .clk(clk), .rst(rst), .smp_vld(vld1), .x_in(x_in), .y_in(y_in), .is_in(is_in),
      .Rdy(rdy1), .Xout(xo1), .Yout(yo1), .ISout(is1), .busy(busy1), .drop_cnt(drop1)
   );

   nco_out_serializer #(.W(12), .SLICE(2), .GAP(0)) u_dut0 (
      .clk(clk), .rst(rst), .smp_vld(vld0), .x_in(x_in), .y_in(y_in), .is_in(is_in),
      .Rdy(rdy0), .Xout(xo0), .Yout(yo0), .ISout(is0), .busy(busy0), .drop_cnt(drop0)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_sched();
      for (int i = 0; i < 64; i++) begin
         sv[i] = 1'b0; sx[i] = '0; sy[i] = '0; sis[i] = 1'b0;
      end
   endtask

   task automatic sched(input int c, input logic [11:0] x, input logic [11:0] y, input logic is);
      sv[c] = 1'b1; sx[c] = x; sy[c] = y; sis[c] = is;
   endtask

   // Cycle c starts 1 time unit after a rising edge; outputs are captured there.
   task automatic run(input int n, input bit use0);
      for (int c = 0; c < n; c++) begin
         x_in  = sx[c];
         y_in  = sy[c];
         is_in = sis[c];
         vld1  = use0 ? 1'b0 : sv[c];
         vld0  = use0 ? sv[c] : 1'b0;
         c_rdy[c]  = use0 ? rdy0  : rdy1;
         c_x[c]    = use0 ? xo0   : xo1;
         c_y[c]    = use0 ? yo0   : yo1;
         c_is[c]   = use0 ? is0   : is1;
         c_busy[c] = use0 ? busy0 : busy1;
         c_drop[c] = use0 ? drop0 : drop1;
         tick();
      end
      vld1 = 1'b0;
      vld0 = 1'b0;
   endtask

   function automatic logic [11:0] frame_x(input int c0);
      logic [11:0] v;
      v = '0;
      for (int k = 0; k < 6; k++) v[2*k +: 2] = c_x[c0 + k];
      return v;
   endfunction

   function automatic logic [11:0] frame_y(input int c0);
      logic [11:0] v;
      v = '0;
      for (int k = 0; k < 6; k++) v[2*k +: 2] = c_y[c0 + k];
      return v;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({rdy1, xo1, yo1, is1, busy1, drop1} !== 15'd0) begin
         errors++;
         $display("FAIL reset_gap1 got %b expected all zero", {rdy1, xo1, yo1, is1, busy1, drop1});
      end
      checks++;
      if ({rdy0, xo0, yo0, is0, busy0, drop0} !== 15'd0) begin
         errors++;
         $display("FAIL reset_gap0 got %b expected all zero", {rdy0, xo0, yo0, is0, busy0, drop0});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_frame();
      logic [1:0] ex [0:5] = '{2'b00, 2'b11, 2'b01, 2'b01, 2'b10, 2'b10};
      logic [1:0] ey [0:5] = '{2'b01, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00};
      logic [1:0] xe, ye;
      clear_sched();
      sched(0, 12'hA5C, 12'h3F1, 1'b1);
      run(11, 1'b0);
      for (int c = 0; c < 11; c++) begin
         xe = (c >= 2 && c <= 7) ? ex[c-2] : 2'b00;
         ye = (c >= 2 && c <= 7) ? ey[c-2] : 2'b00;
         checks++;
         if (c_rdy[c] !== (c == 1)) begin
            errors++;
            $display("FAIL single_rdy c=%0d got %b expected %b", c, c_rdy[c], (c == 1));
         end
         checks++;
         if (c_x[c] !== xe || c_y[c] !== ye) begin
            errors++;
            $display("FAIL single_xy c=%0d got %b/%b expected %b/%b", c, c_x[c], c_y[c], xe, ye);
         end
         checks++;
         if (c_is[c] !== (c >= 2)) begin
            errors++;
            $display("FAIL single_is c=%0d got %b expected %b", c, c_is[c], (c >= 2));
         end
         checks++;
         if (c_busy[c] !== (c >= 1 && c <= 8)) begin
            errors++;
            $display("FAIL single_busy c=%0d got %b expected %b", c, c_busy[c], (c >= 1 && c <= 8));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] ex [0:5] = '{2'b00, 2'b11, 2'b01, 2'b01, 2'b10, 2'b10};
      logic [1:0] xe;
      logic       ie;
      clear_sched();
      sched(0, 12'hA5C, 12'h3F1, 1'b1);
      sched(3, 12'h001, 12'h000, 1'b0);
      run(17, 1'b1);
      for (int c = 0; c < 17; c++) begin
         xe = (c >= 2 && c <= 7) ? ex[c-2] : ((c == 9) ? 2'b01 : 2'b00);
         ie = (c >= 2 && c <= 8);
         checks++;
         if (c_rdy[c] !== (c == 1 || c == 8)) begin
            errors++;
            $display("FAIL b2b_rdy c=%0d got %b expected %b", c, c_rdy[c], (c == 1 || c == 8));
         end
         checks++;
         if (c_x[c] !== xe) begin
            errors++;
            $display("FAIL b2b_x c=%0d got %b expected %b", c, c_x[c], xe);
         end
         checks++;
         if (c_is[c] !== ie) begin
            errors++;
            $display("FAIL b2b_is c=%0d got %b expected %b", c, c_is[c], ie);
         end
      end
      checks++;
      if (c_drop[16] !== 8'd0) begin
         errors++;
         $display("FAIL b2b_drop got %0d expected 0", c_drop[16]);
      end
      checks++;
      if (c_busy[15] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_busy c=15 got %b expected 0", c_busy[15]);
      end
   endtask

   task automatic test_overwrite();
      clear_sched();
      sched(0, 12'hFFF, 12'h000, 1'b0);
      sched(2, 12'h111, 12'h111, 1'b1);
      sched(3, 12'h222, 12'h222, 1'b0);
      sched(4, 12'h333, 12'h333, 1'b1);
      run(20, 1'b0);
      checks++;
      if (c_rdy[9] !== 1'b1 || c_rdy[17] !== 1'b0) begin
         errors++;
         $display("FAIL ovw_rdy got c9=%b c17=%b expected 1 0", c_rdy[9], c_rdy[17]);
      end
      checks++;
      if (frame_x(10) !== 12'h333 || frame_y(10) !== 12'h333) begin
         errors++;
         $display("FAIL ovw_data got x=%h y=%h expected 333 333", frame_x(10), frame_y(10));
      end
      checks++;
      if (c_is[10] !== 1'b1) begin
         errors++;
         $display("FAIL ovw_is got %b expected 1", c_is[10]);
      end
      checks++;
      if (c_drop[4] !== 8'd1) begin
         errors++;
         $display("FAIL ovw_drop_mid got %0d expected 1", c_drop[4]);
      end
      checks++;
      if (c_drop[19] !== 8'd2) begin
         errors++;
         $display("FAIL ovw_drop got %0d expected 2", c_drop[19]);
      end
      checks++;
      if (c_busy[17] !== 1'b0) begin
         errors++;
         $display("FAIL ovw_busy got %b expected 0", c_busy[17]);
      end
   endtask

   task automatic test_collision();
      int nrdy;
      clear_sched();
      sched(0, 12'h555, 12'hAAA, 1'b0);
      sched(3, 12'h0F0, 12'h0F0, 1'b1);
      sched(8, 12'h00F, 12'h00F, 1'b0);
      run(27, 1'b0);
      nrdy = 0;
      for (int c = 0; c < 27; c++) if (c_rdy[c] === 1'b1) nrdy++;
      checks++;
      if (c_rdy[1] !== 1'b1 || c_rdy[9] !== 1'b1 || c_rdy[17] !== 1'b1 || nrdy != 3) begin
         errors++;
         $display("FAIL col_rdy got c1=%b c9=%b c17=%b count=%0d expected 1 1 1 3",
                  c_rdy[1], c_rdy[9], c_rdy[17], nrdy);
      end
      checks++;
      if (frame_x(10) !== 12'h0F0) begin
         errors++;
         $display("FAIL col_first got %h expected 0f0", frame_x(10));
      end
      checks++;
      if (frame_x(18) !== 12'h00F) begin
         errors++;
         $display("FAIL col_second got %h expected 00f", frame_x(18));
      end
      checks++;
      if (c_is[10] !== 1'b1 || c_is[18] !== 1'b0) begin
         errors++;
         $display("FAIL col_is got %b %b expected 1 0", c_is[10], c_is[18]);
      end
      checks++;
      if (c_drop[26] !== 8'd0) begin
         errors++;
         $display("FAIL col_drop got %0d expected 0", c_drop[26]);
      end
      checks++;
      if (c_busy[25] !== 1'b0) begin
         errors++;
         $display("FAIL col_busy got %b expected 0", c_busy[25]);
      end
   endtask

   task automatic test_reset_mid_frame();
      int nrdy, nbusy;
      clear_sched();
      sched(0, 12'hFFF, 12'hFFF, 1'b1);
      sched(3, 12'h0F0, 12'h0F0, 1'b0);
      run(5, 1'b0);
      checks++;
      if (xo1 !== 2'b11 || busy1 !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre got x=%b busy=%b expected 11 1", xo1, busy1);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({rdy1, xo1, yo1, is1, busy1, drop1} !== 15'd0) begin
         errors++;
         $display("FAIL rstmid_async got %b expected all zero", {rdy1, xo1, yo1, is1, busy1, drop1});
      end
      tick();
      rst = 1'b0;
      clear_sched();
      run(12, 1'b0);
      nrdy = 0;
      nbusy = 0;
      for (int c = 0; c < 12; c++) begin
         if (c_rdy[c] !== 1'b0) nrdy++;
         if (c_busy[c] !== 1'b0) nbusy++;
      end
      checks++;
      if (nrdy != 0 || nbusy != 0) begin
         errors++;
         $display("FAIL rstmid_quiet got rdy_cycles=%0d busy_cycles=%0d expected 0 0", nrdy, nbusy);
      end
   endtask

   task automatic test_terminal();
      logic [11:0] x, dout;
      clear_sched();
      sched(0, 12'h7FF, 12'h000, 1'b0);
      run(10, 1'b0);
      x = frame_x(2);
      dout = c_is[8] ? (~x + 12'd1) : x;
      checks++;
      if (dout !== 12'h7FF) begin
         errors++;
         $display("FAIL term_pos got %h expected 7ff", dout);
      end
      clear_sched();
      sched(0, 12'h7FF, 12'h000, 1'b1);
      run(10, 1'b0);
      x = frame_x(2);
      dout = c_is[8] ? (~x + 12'd1) : x;
      checks++;
      if (dout !== 12'h801) begin
         errors++;
         $display("FAIL term_neg got %h expected 801", dout);
      end
   endtask

   task automatic test_saturation();
      x_in = 12'h123;
      y_in = 12'h456;
      is_in = 1'b0;
      vld1 = 1'b1;
      for (int c = 0; c < 400; c++) tick();
      vld1 = 1'b0;
      for (int c = 0; c < 30; c++) tick();
      checks++;
      if (drop1 !== 8'd255) begin
         errors++;
         $display("FAIL sat_drop got %0d expected 255", drop1);
      end
      checks++;
      if (busy1 !== 1'b0) begin
         errors++;
         $display("FAIL sat_drain got busy=%b expected 0", busy1);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_reset();
      test_back_to_back();
      test_reset();
      test_overwrite();
      test_reset();
      test_collision();
      test_reset();
      test_reset_mid_frame();
      test_reset();
      test_terminal();
      test_reset();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
